// File: rtl/ctrl_pkg.sv
// Shared types and codes for the multi-cycle RV64 control sequencer:
// state encoding, opcodes, instruction classes, ALU op and trap codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_SD,
        CLS_BEQ
    } cls_t;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LD  = 7'h03;
    localparam logic [6:0] OP_SD  = 7'h23;
    localparam logic [6:0] OP_BEQ = 7'h63;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_ILL  = 2'b01;
    localparam logic [1:0] CAUSE_IMEM = 2'b10;
    localparam logic [1:0] CAUSE_DMEM = 2'b11;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode classifier: instr -> instruction class, illegal flag.
// Ports: instr (IR), cls (class, NONE for halt word), illegal.
import ctrl_pkg::*;

module ctrl_opcode_decode #(
    parameter int HALT_ON_ZERO = 1
) (
    input  logic [31:0] instr,
    output cls_t        cls,
    output logic        illegal
);

    logic [6:0] op;
    logic       halt_word;

    assign op        = instr[6:0];
    assign halt_word = (HALT_ON_ZERO != 0) && (instr == 32'd0);

    // A halt word reports CLS_NONE with illegal low.
    always_comb begin
        cls     = CLS_NONE;
        illegal = 1'b0;
        unique case (1'b1)
            (op == OP_R):   cls = CLS_R;
            (op == OP_I):   cls = CLS_I;
            (op == OP_LD):  cls = CLS_LD;
            (op == OP_SD):  cls = CLS_SD;
            (op == OP_BEQ): cls = CLS_BEQ;
            halt_word:      cls = CLS_NONE;
            default:        illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with imem/dmem wait
// states and bus timeout. Ports: run/instr/alu_zero/readys in; enables out.
import ctrl_pkg::*;

module multicycle_ctrl_fsm #(
    parameter int TIMEOUT_CYC  = 255,
    parameter int HALT_ON_ZERO = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        retire,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state, state_n;
    cls_t        cls_q, dec_cls;
    logic        dec_illegal;
    logic [15:0] wait_cnt;
    logic [1:0]  cause_q, cause_n;
    logic        timed_out;
    state_t      boundary;

    ctrl_opcode_decode #(
        .HALT_ON_ZERO(HALT_ON_ZERO)
    ) u_dec (
        .instr  (instr),
        .cls    (dec_cls),
        .illegal(dec_illegal)
    );

    // Count holds only while parked in FETCH/MEM; any transition clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cls_q    <= CLS_NONE;
            wait_cnt <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state   <= state_n;
            cause_q <= cause_n;
            if (state == S_DECODE)
                cls_q <= dec_cls;
            if (state_n == state && (state == S_FETCH || state == S_MEM))
                wait_cnt <= wait_cnt + 16'd1;
            else
                wait_cnt <= '0;
        end
    end

    // Not-ready cycle that would make the count hit the limit.
    assign timed_out = (wait_cnt == TO_LAST);
    assign boundary  = run ? S_FETCH : S_IDLE;

    always_comb begin
        state_n    = state;
        cause_n    = cause_q;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run)
                    state_n = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = S_DECODE;
                end else if (timed_out) begin
                    state_n = S_TRAP;
                    cause_n = CAUSE_IMEM;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_n = S_TRAP;
                    cause_n = CAUSE_ILL;
                end else if (dec_cls == CLS_NONE) begin
                    state_n = S_HALT;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (cls_q)
                    CLS_R: begin
                        alu_op  = ALU_FUNCT;
                        state_n = S_WB;
                    end
                    CLS_I: begin
                        alu_src = 1'b1;
                        state_n = S_WB;
                    end
                    CLS_LD, CLS_SD: begin
                        alu_src = 1'b1;
                        state_n = S_MEM;
                    end
                    CLS_BEQ: begin
                        alu_op = ALU_SUB;
                        if (alu_zero) begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                        end
                        retire  = 1'b1;
                        state_n = boundary;
                    end
                    default: begin
                        state_n = S_TRAP;
                        cause_n = CAUSE_ILL;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CLS_SD);
                if (dmem_ready) begin
                    if (cls_q == CLS_SD) begin
                        retire  = 1'b1;
                        state_n = boundary;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (timed_out) begin
                    state_n = S_TRAP;
                    cause_n = CAUSE_DMEM;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == CLS_LD);
                retire     = 1'b1;
                state_n    = boundary;
            end
            S_HALT, S_TRAP: begin
                state_n = state;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign halted     = (state == S_HALT);
    assign trap       = (state == S_TRAP);
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: small datapath around the DUT plus an
// ISA-level reference model and latency table, random wait states.
module tb_multicycle_ctrl_fsm;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset, run, alu_zero, imem_ready, dmem_ready;
    logic [31:0] instr;
    logic        imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we;
    logic        alu_src, mem_to_reg, reg_write, retire, halted, trap;
    logic [1:0]  alu_op, trap_cause;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .TIMEOUT_CYC (TO),
        .HALT_ON_ZERO(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .instr     (instr),
        .alu_zero  (alu_zero),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .imem_req  (imem_req),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .mem_to_reg(mem_to_reg),
        .reg_write (reg_write),
        .retire    (retire),
        .halted    (halted),
        .trap      (trap),
        .trap_cause(trap_cause)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Datapath environment
    logic [31:0] imem [64];
    logic [63:0] dmem [32];
    logic [63:0] rf [32];
    logic [63:0] pc, old_pc, aluout, mdr;
    // Reference model state
    logic [63:0] m_rf [32];
    logic [63:0] m_dmem [32];
    logic [63:0] m_pc;
    int m_ret;
    int cyc, fcnt, dcnt, fw, dw, fw_force, dw_force, f_start;
    int n_ret, n_pcw;

    function automatic logic [15:0] outs();
        return {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we,
                alu_src, alu_op, mem_to_reg, reg_write, retire, halted,
                trap, trap_cause};
    endfunction

    function automatic logic [63:0] imm_i(input logic [31:0] i);
        return {{52{i[31]}}, i[31:20]};
    endfunction
    function automatic logic [63:0] imm_s(input logic [31:0] i);
        return {{52{i[31]}}, i[31:25], i[11:7]};
    endfunction
    function automatic logic [63:0] imm_b(input logic [31:0] i);
        return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1,
                                          int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(int op, int imm, int rs1,
                                          int f3, int rd);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        logic [11:0] s;
        s = 12'(imm);
        return {s[11:5], 5'(rs2), 5'(rs1), 3'd3, s[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1);
        logic [12:0] b;
        b = 13'(imm);
        return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'd0, b[4:1], b[11], 7'h63};
    endfunction

    function automatic logic [31:0] imem_rd(input logic [63:0] a);
        if (a >= 64'd256) return 32'd0;
        return imem[a[7:2]];
    endfunction

    // ALU as wired in the datapath, steered by the DUT's control outputs.
    function automatic logic [63:0] alu_res();
        logic [63:0] a, b;
        a = rf[instr[19:15]];
        if (alu_src)
            b = (instr[6:0] == 7'h23) ? imm_s(instr) : imm_i(instr);
        else
            b = rf[instr[24:20]];
        case (alu_op)
            2'b00: return a + b;
            2'b01: return a - b;
            default: begin
                case (instr[14:12])
                    3'd7: return a & b;
                    3'd6: return a | b;
                    default: return instr[30] ? a - b : a + b;
                endcase
            end
        endcase
    endfunction

    // Architectural execution of one instruction; lat = expected cycles.
    task automatic m_step(output int lat);
        logic [31:0] i;
        logic [63:0] a, b, ea, nx;
        logic [4:0]  rd;
        int base;
        logic mem;
        i = imem_rd(m_pc);
        a = m_rf[i[19:15]];
        b = m_rf[i[24:20]];
        rd = i[11:7];
        nx = m_pc + 64'd4;
        mem = 1'b0;
        base = 4;
        case (i[6:0])
            7'h33: begin
                case (i[14:12])
                    3'd7: m_rf[rd] = a & b;
                    3'd6: m_rf[rd] = a | b;
                    default: m_rf[rd] = i[30] ? a - b : a + b;
                endcase
            end
            7'h13: m_rf[rd] = a + imm_i(i);
            7'h03: begin
                ea = a + imm_i(i);
                m_rf[rd] = m_dmem[ea[7:3]];
                base = 5;
                mem = 1'b1;
            end
            7'h23: begin
                ea = a + imm_s(i);
                m_dmem[ea[7:3]] = b;
                mem = 1'b1;
            end
            7'h63: begin
                base = 3;
                if (a == b) nx = m_pc + imm_b(i);
            end
            default: base = 0;
        endcase
        m_rf[0] = 64'd0;
        m_pc = nx;
        m_ret++;
        lat = base + fw + (mem ? dw : 0);
    endtask

    task automatic step();
        logic [63:0] p;
        logic [4:0]  rd;
        int el;
        @(negedge clk);
        if (imem_req) begin
            if (fcnt == 0) begin
                fw = (fw_force >= 0) ? fw_force : int'($urandom_range(0, TO - 1));
                dw = (dw_force >= 0) ? dw_force : int'($urandom_range(0, TO - 1));
                f_start = cyc;
            end
            imem_ready = (fcnt == fw);
            fcnt++;
        end else begin
            imem_ready = 1'b0;
            fcnt = 0;
        end
        if (dmem_req) begin
            dmem_ready = (dcnt == dw);
            dcnt++;
        end else begin
            dmem_ready = 1'b0;
            dcnt = 0;
        end
        alu_zero = (alu_res() == 64'd0);
        #1;
        p = pc;
        rd = instr[11:7];
        if (alu_src || alu_op != 2'b00) aluout = alu_res();
        if (dmem_req && dmem_ready) begin
            if (dmem_we) dmem[aluout[7:3]] = rf[instr[24:20]];
            else mdr = dmem[aluout[7:3]];
        end
        if (reg_write && rd != 5'd0) rf[rd] = mem_to_reg ? mdr : aluout;
        if (pc_write) begin
            n_pcw++;
            pc = pc_src ? old_pc + imm_b(instr) : p + 64'd4;
        end
        if (ir_write) begin
            instr = imem_rd(p);
            old_pc = p;
        end
        if (retire) begin
            n_ret++;
            m_step(el);
            chk("latency", 64'(cyc - f_start + 1), 64'(el));
            chk("pc", pc, m_pc);
            chk("rd_val", rf[rd], m_rf[rd]);
        end
        cyc++;
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 64; k++) imem[k] = 32'd0;
        for (int k = 0; k < 32; k++) dmem[k] = 64'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        alu_zero = 1'b1;
        instr = 32'd0;
        pc = '0; old_pc = '0; aluout = '0; mdr = '0; m_pc = '0;
        for (int k = 0; k < 32; k++) begin
            rf[k] = '0;
            m_rf[k] = '0;
            m_dmem[k] = dmem[k];
        end
        cyc = 0; fcnt = 0; dcnt = 0; n_ret = 0; m_ret = 0; n_pcw = 0;
        fw = 0; dw = 0; f_start = 0;
        repeat (2) @(negedge clk);
        #1 chk("reset_outs", 64'(outs()), 64'd0);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        alu_zero = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_until(input int budget);
        for (int k = 0; k < budget && !(halted || trap); k++) step();
        chk("stopped", 64'(halted | trap), 64'd1);
    endtask

    task automatic gen_prog(input int n);
        int ty, rd, rs1, rs2;
        clear_mem();
        for (int k = 0; k < 32; k++) dmem[k] = {$urandom, $urandom};
        for (int i = 0; i < n; i++) begin
            ty = $urandom_range(0, 4);
            rd = $urandom_range(1, 7);
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            case (ty)
                0: begin
                    case ($urandom_range(0, 3))
                        0: imem[i] = enc_r(0, rs2, rs1, 0, rd);
                        1: imem[i] = enc_r(32, rs2, rs1, 0, rd);
                        2: imem[i] = enc_r(0, rs2, rs1, 7, rd);
                        default: imem[i] = enc_r(0, rs2, rs1, 6, rd);
                    endcase
                end
                1: imem[i] = enc_i(7'h13, int'($urandom_range(0, 4095)), rs1, 0, rd);
                2: imem[i] = enc_i(7'h03, 8 * int'($urandom_range(0, 31)), 0, 3, rd);
                3: imem[i] = enc_s(8 * int'($urandom_range(0, 31)), rs2, 0);
                default: imem[i] = enc_b(4 * int'($urandom_range(1, n - i)),
                                         int'($urandom_range(0, 3)),
                                         int'($urandom_range(0, 3)));
            endcase
        end
    endtask

    initial begin
        int nf, nd, nrw, nwe, bad;
        reset = 1'b0;
        run = 1'b0;
        fw_force = -1;
        dw_force = -1;

        // Countdown loop program
        clear_mem();
        imem[0] = enc_i(7'h13, 2, 0, 0, 1);
        imem[1] = enc_i(7'h13, 7, 0, 0, 2);
        imem[2] = enc_b(16, 0, 1);
        imem[3] = enc_r(0, 1, 2, 0, 2);
        imem[4] = enc_i(7'h13, -1, 1, 0, 1);
        imem[5] = enc_b(-12, 0, 0);
        do_reset();
        run = 1'b1;
        run_until(2000);
        chk("p1_halted", 64'(halted), 64'd1);
        chk("p1_x1", rf[1], 64'd0);
        chk("p1_x2", rf[2], 64'd10);
        chk("p1_retires", 64'(n_ret), 64'(m_ret));

        // Random straight-line/forward-branch programs, random waits
        for (int t = 0; t < 8; t++) begin
            gen_prog(12);
            do_reset();
            run = 1'b1;
            run_until(2000);
            chk("rnd_halted", 64'(halted), 64'd1);
            chk("rnd_retires", 64'(n_ret), 64'(m_ret));
            for (int r = 1; r < 8; r++) chk("rnd_reg", rf[r], m_rf[r]);
            bad = 0;
            for (int k = 0; k < 32; k++) if (dmem[k] !== m_dmem[k]) bad++;
            chk("rnd_dmem", 64'(bad), 64'd0);
        end

        // ld with 3 dmem wait cycles
        clear_mem();
        dmem[0] = 64'h1234_5678_9abc_def0;
        imem[0] = enc_i(7'h03, 0, 0, 3, 3);
        fw_force = 0;
        dw_force = 3;
        do_reset();
        run = 1'b1;
        nd = 0;
        for (int k = 0; k < 40 && !(halted || trap); k++) begin
            step();
            if (dmem_req) nd++;
        end
        chk("ld_req_cycles", 64'(nd), 64'd4);
        chk("ld_x3", rf[3], 64'h1234_5678_9abc_def0);
        chk("ld_halted", 64'(halted), 64'd1);

        // sd: store only, no register write
        clear_mem();
        imem[0] = enc_i(7'h13, 'h55, 0, 0, 4);
        imem[1] = enc_s(16, 4, 0);
        dw_force = 0;
        do_reset();
        run = 1'b1;
        nrw = 0;
        nwe = 0;
        for (int k = 0; k < 40 && !(halted || trap); k++) begin
            step();
            if (reg_write) nrw++;
            if (dmem_we) nwe++;
        end
        chk("sd_regwrites", 64'(nrw), 64'd1);
        chk("sd_we_cycles", 64'(nwe), 64'd1);
        chk("sd_mem", dmem[2], 64'h55);

        // imem ready on the last allowed cycle: no trap
        clear_mem();
        imem[0] = enc_i(7'h13, 5, 0, 0, 1);
        fw_force = TO - 1;
        do_reset();
        run = 1'b1;
        run_until(100);
        chk("late_ready_trap", 64'(trap), 64'd0);
        chk("late_ready_x1", rf[1], 64'd5);

        // imem never ready: timeout trap
        fw_force = 1000;
        do_reset();
        run = 1'b1;
        nf = 0;
        for (int k = 0; k < 40 && !trap; k++) begin
            step();
            if (imem_req) nf++;
        end
        chk("imem_to_trap", 64'(trap), 64'd1);
        chk("imem_to_cause", 64'(trap_cause), 64'd2);
        chk("imem_to_cycles", 64'(nf), 64'(TO));
        repeat (4) step();
        chk("trap_sticky", 64'({trap, imem_req, halted}), 64'b100);

        // dmem never ready: timeout trap
        clear_mem();
        imem[0] = enc_i(7'h03, 0, 0, 3, 3);
        fw_force = 0;
        dw_force = 1000;
        do_reset();
        run = 1'b1;
        nd = 0;
        for (int k = 0; k < 40 && !trap; k++) begin
            step();
            if (dmem_req) nd++;
        end
        chk("dmem_to_cause", 64'(trap_cause), 64'd3);
        chk("dmem_to_cycles", 64'(nd), 64'(TO));

        // illegal opcode
        clear_mem();
        imem[0] = 32'h0000_007F;
        dw_force = 0;
        do_reset();
        run = 1'b1;
        run_until(40);
        chk("ill_cause", 64'({trap, trap_cause}), 64'b101);
        chk("ill_pcwrites", 64'(n_pcw), 64'd1);
        chk("ill_pc", pc, 64'd4);

        // run dropped during EXEC of add
        clear_mem();
        imem[0] = enc_r(0, 0, 0, 0, 5);
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 20 && alu_op != 2'b10; k++) step();
        chk("drop_in_exec", 64'(alu_op), 64'd2);
        run = 1'b0;
        step();
        chk("drop_retire", 64'({retire, reg_write}), 64'b11);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("drop_idle", 64'(outs()), 64'd0);
        end
        run = 1'b1;
        step();
        chk("drop_resume", 64'(imem_req), 64'd1);

        // reset asserted in the middle of MEM
        clear_mem();
        imem[0] = enc_i(7'h03, 0, 0, 3, 3);
        dw_force = 6;
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 20 && !dmem_req; k++) step();
        step();
        step();
        chk("mem_before_rst", 64'(dmem_req), 64'd1);
        reset = 1'b0;
        #1 chk("rst_mid_mem", 64'(outs()), 64'd0);
        run = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        chk("rst_idle", 64'(outs()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
